// File: rtl/mem_responder_pkg.sv
// Shared types and sizes for the external-bus memory responder.
//   WORD_SIZE / BYTE_SIZE : address and data widths of the CPU bus
//   MAX_WAIT_STATES       : largest wait-state count the counter can hold
//   state_t / region_t / acc_t / req_t : FSM, decode and latched-request types
package mem_responder_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int BYTE_SIZE       = 8;
    localparam int MAX_WAIT_STATES = 15;
    localparam int WAIT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_ROM  = 2'd1,
        REG_RAM  = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        ACC_READ  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_BOTH  = 2'd2
    } acc_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] addr;
        region_t              region;
        acc_t                 kind;
        logic [BYTE_SIZE-1:0] wdata;
    } req_t;

    // ROM takes priority if a misconfigured map ever lets the regions overlap.
    function automatic region_t region_of(input logic rom_en, input logic ram_en);
        if (rom_en) return REG_ROM;
        if (ram_en) return REG_RAM;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/handshake signals and the ROM preload port of the memory responder.
// The shared data bus is not part of this bundle; it stays a plain inout on the
// responder so the tristate resolution lives on a single top-level net.
//   addr_bus, read_en, write_en      : CPU request (master -> slave)
//   mem_ready, bus_err               : completion / rejection pulses (slave -> master)
//   load_en, load_addr, load_data    : ROM preload request (master -> slave)
//   load_ack                         : preload completion pulse (slave -> master)
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [WORD_SIZE-1:0] addr_bus;
    logic                 read_en;
    logic                 write_en;
    logic                 mem_ready;
    logic                 bus_err;
    logic                 load_en;
    logic [WORD_SIZE-1:0] load_addr;
    logic [BYTE_SIZE-1:0] load_data;
    logic                 load_ack;

    modport master (
        output addr_bus, read_en, write_en, load_en, load_addr, load_data,
        input  mem_ready, bus_err, load_ack
    );

    modport slave (
        input  addr_bus, read_en, write_en, load_en, load_addr, load_data,
        output mem_ready, bus_err, load_ack
    );

endinterface

// File: rtl/mem_responder_addr_decoder.sv
// Region decode for the memory responder.
//   addr   : CPU address
//   rom_en : address falls in [0, ROM_SIZE)
//   ram_en : address falls in [RAM_BASE, RAM_BASE + RAM_SIZE)
module mem_responder_addr_decoder
    import mem_responder_pkg::*;
#(
    parameter int                   ROM_SIZE = 256,
    parameter int                   RAM_SIZE = 256,
    parameter logic [WORD_SIZE-1:0] RAM_BASE = 16'h8000
) (
    input  logic [WORD_SIZE-1:0] addr,
    output logic                 rom_en,
    output logic                 ram_en
);

    // Compare in 32 bits so RAM_BASE + RAM_SIZE cannot wrap at the top of the map.
    assign rom_en = 32'(addr) < ROM_SIZE;
    assign ram_en = (32'(addr) >= 32'(RAM_BASE)) && (32'(addr) < 32'(RAM_BASE) + RAM_SIZE);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU external bus: ROM + RAM arrays, configurable
// wait states, error flagging for illegal accesses and a ROM preload port.
//   clk          : single clock, posedge
//   reset        : synchronous, active high; array contents survive it
//   bus          : request/handshake/preload signals (mem_responder_if.slave)
//   ext_data_bus : shared data bus, driven here only while returning read data
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no access in flight; preload may be accepted
// WAIT    | request latched, counting down wait states
// RESP    | access performed on entry; mem_ready/bus_err pulse; may re-accept
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                   ROM_SIZE    = 256,
    parameter int                   RAM_SIZE    = 256,
    parameter logic [WORD_SIZE-1:0] RAM_BASE    = 16'h8000,
    parameter int                   WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_responder_if.slave       bus,
    inout  wire  [BYTE_SIZE-1:0] ext_data_bus
);

    localparam int ROM_AW   = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1;
    localparam int RAM_AW   = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam int WAIT_EFF = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;

    logic [BYTE_SIZE-1:0] rom [ROM_SIZE];
    logic [BYTE_SIZE-1:0] ram [RAM_SIZE];

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    cnt_q, cnt_d;
    req_t                 req_q, req_live, acc;
    logic                 rom_en, ram_en;
    logic [BYTE_SIZE-1:0] data_q;
    logic                 drive_q, mem_ready_q, bus_err_q, load_ack_q;
    logic                 cpu_req, accept, do_access;
    logic                 acc_rd_ok, acc_ram_wr, acc_err, acc_ready;
    logic                 load_take, load_in_range;
    logic [ROM_AW-1:0]    rom_idx, load_idx;
    logic [RAM_AW-1:0]    ram_idx;

    mem_responder_addr_decoder #(
        .ROM_SIZE (ROM_SIZE),
        .RAM_SIZE (RAM_SIZE),
        .RAM_BASE (RAM_BASE)
    ) u_addr_decoder (
        .addr   (bus.addr_bus),
        .rom_en (rom_en),
        .ram_en (ram_en)
    );

    assign cpu_req = bus.read_en | bus.write_en;

    always_comb begin
        req_live.addr   = bus.addr_bus;
        req_live.region = region_of(rom_en, ram_en);
        req_live.kind   = (bus.read_en && bus.write_en) ? ACC_BOTH :
                          bus.write_en                  ? ACC_WRITE : ACC_READ;
        req_live.wdata  = ext_data_bus;
    end

    // With zero wait states the access happens on the accepting edge, so it must
    // use the live request; otherwise it uses the copy latched on entry to WAIT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        do_access = 1'b0;
        acc       = req_live;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (cpu_req) begin
                    accept = 1'b1;
                    if (WAIT_EFF == 0) begin
                        state_d   = ST_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_W'(WAIT_EFF);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                acc = req_q;
                if (cnt_q <= WAIT_W'(1)) begin
                    state_d   = ST_RESP;
                    cnt_d     = '0;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc_rd_ok  = do_access && (acc.kind == ACC_READ) && (acc.region != REG_NONE);
    assign acc_ram_wr = do_access && (acc.kind == ACC_WRITE) && (acc.region == REG_RAM);
    assign acc_err    = do_access && ((acc.kind == ACC_BOTH) || (acc.region == REG_NONE) ||
                                      ((acc.kind == ACC_WRITE) && (acc.region == REG_ROM)));
    // Simultaneous read+write is a protocol error, not an access: no completion pulse.
    assign acc_ready  = do_access && (acc.kind != ACC_BOTH);

    assign rom_idx = ROM_AW'(acc.addr);
    assign ram_idx = RAM_AW'(acc.addr - RAM_BASE);

    // CPU wins arbitration; the held load_en is ignored while its ack is showing
    // so one preload produces exactly one ack pulse.
    assign load_take     = bus.load_en && (state_q == ST_IDLE) && !cpu_req && !load_ack_q;
    assign load_in_range = 32'(bus.load_addr) < ROM_SIZE;
    assign load_idx      = ROM_AW'(bus.load_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            data_q      <= '0;
            drive_q     <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            load_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_ready_q <= acc_ready;
            bus_err_q   <= acc_err;
            load_ack_q  <= load_take;
            if (accept) begin
                req_q <= req_live;
            end
            if (acc_rd_ok) begin
                data_q <= (acc.region == REG_ROM) ? rom[rom_idx] : ram[ram_idx];
            end
            if (!bus.read_en) begin
                drive_q <= 1'b0;
            end else if (do_access) begin
                drive_q <= acc_rd_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && acc_ram_wr) begin
            ram[ram_idx] <= acc.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && load_take && load_in_range) begin
            rom[load_idx] <= bus.load_data;
        end
    end

    assign bus.mem_ready = mem_ready_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.load_ack  = load_ack_q;
    assign ext_data_bus  = (bus.read_en && drive_q) ? data_q : {BYTE_SIZE{1'bz}};

endmodule
